opb_reg_bank_ctrl: RTL and testbench

OPB slave controller that exposes a bank of C_NUM_REGS software-readable user registers through one OPB slave port, replacing one simulink2ppc register core per value. It decodes the address window, sequences a fixed-latency read/write handshake with wait states, and optionally freezes all registers atomically so software reads a coherent snapshot. It sits on the ROACH OPB bus beside the existing register cores; user_data_in is produced in the OPB_Clk domain.

---
 rtl/opb_reg_bank_pkg.sv | 19 +
 rtl/opb_reg_bank_shadow.sv | 38 +++
 rtl/opb_reg_bank_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_opb_reg_bank_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_reg_bank_pkg.sv
// Shared types and helpers for the OPB user register bank controller.
package opb_reg_bank_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } opb_state_e;

  // Bit position of the freeze flag in CTRL, using OPB big-endian numbering (bit 31 = LSB).
  localparam int unsigned CtrlFrozenBit = 31;
  localparam int unsigned WaitCntW      = 4;

  // Width of a register index covering the user registers plus the CTRL slot.
  function automatic int unsigned off_width(input int unsigned num_regs);
    return $clog2(num_regs + 1);
  endfunction

endpackage

// File: rtl/opb_reg_bank_shadow.sv
// Snapshot bank: captures every user register in one cycle and muxes shadow or live read data.
module opb_reg_bank_shadow
  import opb_reg_bank_pkg::*;
#(
  parameter int unsigned NumRegs = 8,
  parameter int unsigned IdxW    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   capture_i,
  input  logic                   use_shadow_i,
  input  logic [IdxW-1:0]        idx_i,
  input  logic [NumRegs*32-1:0]  live_bus_i,
  input  logic [31:0]            live_word_i,
  output logic [31:0]            rd_word_o
);

  logic [NumRegs*32-1:0] shadow_q;
  logic [31:0]           shadow_word;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else if (capture_i) begin
      shadow_q <= live_bus_i;
    end
  end

  always_comb begin
    shadow_word = '0;
    for (int k = 0; k < int'(NumRegs); k++) begin
      if (idx_i == IdxW'(k)) shadow_word = shadow_q[k*32 +: 32];
    end
  end

  assign rd_word_o = use_shadow_i ? shadow_word : live_word_i;

endmodule

// File: rtl/opb_reg_bank_ctrl.sv
// OPB slave exposing C_NUM_REGS read-only user registers plus a CTRL word (freeze flag).
// Optional snapshot bank enabled by defining OPB_REG_BANK_SNAPSHOT_EN.
module opb_reg_bank_ctrl
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h01008600,
  parameter logic [31:0] C_HIGHADDR    = 32'h010086FF,
  parameter int unsigned C_NUM_REGS    = 8,
  parameter int unsigned C_WAIT_CYCLES = 2
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [C_NUM_REGS*32-1:0] user_data_in
);

  localparam int unsigned IdxW = off_width(C_NUM_REGS);
  localparam logic [WaitCntW-1:0] WaitLoad =
      WaitCntW'((C_WAIT_CYCLES == 0) ? 0 : C_WAIT_CYCLES - 1);

  opb_state_e state_q, state_d;
  logic [WaitCntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                rnw_q, rnw_d;
  logic                be3_q, be3_d;
  logic                d31_q, d31_d;
  logic                is_reg_q, is_reg_d;
  logic                is_ctrl_q, is_ctrl_d;
  logic                frozen_q, frozen_d;
  logic [0:31]         rdata_q, rdata_d;

  // Bus-side decode.
  logic [31:0]     abus, rel, bus_word;
  logic            bus_hit, bus_is_reg, bus_is_ctrl;
  logic [IdxW-1:0] bus_idx;

  assign abus        = OPB_ABus;
  assign rel         = abus - C_BASEADDR;
  assign bus_word    = rel >> 2;
  assign bus_hit     = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign bus_is_reg  = bus_word < 32'(C_NUM_REGS);
  assign bus_is_ctrl = bus_word == 32'(C_NUM_REGS);
  assign bus_idx     = bus_word[IdxW-1:0];

  // In IDLE the transfer is taken straight from the bus (zero-wait case); later from the latch.
  logic            cur_rnw, cur_is_reg, cur_is_ctrl;
  logic [IdxW-1:0] cur_idx;

  assign cur_rnw     = (state_q == StIdle) ? OPB_RNW     : rnw_q;
  assign cur_is_reg  = (state_q == StIdle) ? bus_is_reg  : is_reg_q;
  assign cur_is_ctrl = (state_q == StIdle) ? bus_is_ctrl : is_ctrl_q;
  assign cur_idx     = (state_q == StIdle) ? bus_idx     : idx_q;

  logic [31:0] live_word, user_word;
  logic [0:31] read_word;

  always_comb begin
    live_word = '0;
    for (int k = 0; k < int'(C_NUM_REGS); k++) begin
      if (cur_idx == IdxW'(k)) live_word = user_data_in[k*32 +: 32];
    end
  end

`ifdef OPB_REG_BANK_SNAPSHOT_EN
  logic capture;
  // Capture only on the 0->1 freeze transition so a repeated freeze keeps the first image.
  assign capture = frozen_d && !frozen_q;

  opb_reg_bank_shadow #(
    .NumRegs (C_NUM_REGS),
    .IdxW    (IdxW)
  ) u_shadow (
    .clk_i        (OPB_Clk),
    .rst_ni       (OPB_Rst_n),
    .capture_i    (capture),
    .use_shadow_i (frozen_q),
    .idx_i        (cur_idx),
    .live_bus_i   (user_data_in),
    .live_word_i  (live_word),
    .rd_word_o    (user_word)
  );
`else
  assign user_word = live_word;
`endif

  always_comb begin
    read_word = '0;
    if (cur_rnw) begin
      if (cur_is_reg) begin
        read_word = user_word;
      end else if (cur_is_ctrl) begin
        read_word[CtrlFrozenBit] = frozen_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rnw_d     = rnw_q;
    be3_d     = be3_q;
    d31_d     = d31_q;
    is_reg_d  = is_reg_q;
    is_ctrl_d = is_ctrl_q;
    frozen_d  = frozen_q;
    rdata_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (bus_hit) begin
          idx_d     = bus_idx;
          rnw_d     = OPB_RNW;
          be3_d     = OPB_BE[3];
          d31_d     = OPB_DBus[CtrlFrozenBit];
          is_reg_d  = bus_is_reg;
          is_ctrl_d = bus_is_ctrl;
          if (C_WAIT_CYCLES == 0) begin
            state_d = StAck;
            rdata_d = read_word;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (!OPB_select) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StAck;
          rdata_d = read_word;
        end else begin
          cnt_d = cnt_q - WaitCntW'(1);
        end
      end
      StAck: begin
        state_d = StIdle;
        if (!rnw_q && is_ctrl_q && be3_q) frozen_d = d31_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      rnw_q     <= 1'b0;
      be3_q     <= 1'b0;
      d31_q     <= 1'b0;
      is_reg_q  <= 1'b0;
      is_ctrl_q <= 1'b0;
      frozen_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rnw_q     <= rnw_d;
      be3_q     <= be3_d;
      d31_q     <= d31_d;
      is_reg_q  <= is_reg_d;
      is_ctrl_q <= is_ctrl_d;
      frozen_q  <= frozen_d;
      rdata_q   <= rdata_d;
    end
  end

  assign Sl_DBus    = rdata_q;
  assign Sl_xferAck = (state_q == StAck) && (is_reg_q || is_ctrl_q);
  assign Sl_errAck  = (state_q == StAck) && !(is_reg_q || is_ctrl_q);
  assign Sl_toutSup = (state_q == StWait);
  assign Sl_retry   = 1'b0;

  logic unused_bus;
  assign unused_bus = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:30]};

endmodule

// File: tb/tb_opb_reg_bank_ctrl.sv
// Directed bench for opb_reg_bank_ctrl: a 2-wait-state instance and a zero-wait instance.
module tb_opb_reg_bank_ctrl;

  localparam int unsigned NumRegs = 8;
`ifdef OPB_REG_BANK_SNAPSHOT_EN
  localparam bit Snap = 1'b1;
`else
  localparam bit Snap = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NumRegs*32-1:0] user_data = '0;

  logic [0:31] a_abus, a_wdata, a_dbus;
  logic [0:3]  a_be;
  logic        a_rnw, a_sel, a_ack, a_err, a_retry, a_tout;
  logic [0:31] b_abus, b_wdata, b_dbus;
  logic [0:3]  b_be;
  logic        b_rnw, b_sel, b_ack, b_err, b_retry, b_tout;

  opb_reg_bank_ctrl #(
    .C_BASEADDR    (32'h01008600),
    .C_HIGHADDR    (32'h010086FF),
    .C_NUM_REGS    (NumRegs),
    .C_WAIT_CYCLES (2)
  ) u_dut_a (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (a_abus),
    .OPB_BE       (a_be),
    .OPB_DBus     (a_wdata),
    .OPB_RNW      (a_rnw),
    .OPB_select   (a_sel),
    .OPB_seqAddr  (1'b0),
    .Sl_DBus      (a_dbus),
    .Sl_xferAck   (a_ack),
    .Sl_errAck    (a_err),
    .Sl_retry     (a_retry),
    .Sl_toutSup   (a_tout),
    .user_data_in (user_data)
  );

  opb_reg_bank_ctrl #(
    .C_BASEADDR    (32'h01008600),
    .C_HIGHADDR    (32'h010086FF),
    .C_NUM_REGS    (NumRegs),
    .C_WAIT_CYCLES (0)
  ) u_dut_b (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (b_abus),
    .OPB_BE       (b_be),
    .OPB_DBus     (b_wdata),
    .OPB_RNW      (b_rnw),
    .OPB_select   (b_sel),
    .OPB_seqAddr  (1'b0),
    .Sl_DBus      (b_dbus),
    .Sl_xferAck   (b_ack),
    .Sl_errAck    (b_err),
    .Sl_retry     (b_retry),
    .Sl_toutSup   (b_tout),
    .user_data_in (user_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          ack_cyc, err_cyc, ack_cnt;
  logic [31:0] ack_data, idle_dbus;
  logic [15:0] tout_mask;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input int k, input logic [31:0] v);
    user_data[k*32 +: 32] = v;
  endtask

  // One transfer on DUT A; cycle 1 is the first cycle after the edge that samples the request.
  task automatic xfer_a(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                        input logic [31:0] wdata, input int ncyc, input int drop_at);
    @(negedge clk);
    a_abus = addr; a_rnw = rnw; a_be = be; a_wdata = wdata; a_sel = 1'b1;
    ack_cyc = -1; err_cyc = -1; ack_cnt = 0; ack_data = '0; idle_dbus = '0; tout_mask = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (a_tout) tout_mask[c] = 1'b1;
      if (a_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = c;
        ack_data = a_dbus;
      end else begin
        idle_dbus |= a_dbus;
      end
      if (a_err && err_cyc < 0) err_cyc = c;
      if (a_ack || a_err || c == drop_at) a_sel = 1'b0;
    end
    a_sel = 1'b0;
  endtask

  task automatic read_a(input logic [31:0] addr);
    xfer_a(addr, 1'b1, 4'hF, 32'h0, 6, 0);
  endtask

  logic [31:0] bmask;
  logic [31:0] bd [6];
  int          late_acks;

  initial begin
    a_abus = '0; a_wdata = '0; a_be = '0; a_rnw = 1'b0; a_sel = 1'b0;
    b_abus = '0; b_wdata = '0; b_be = '0; b_rnw = 1'b0; b_sel = 1'b0;
    set_reg(0, 32'h000000AA);
    set_reg(1, 32'h11111111);
    set_reg(3, 32'hDEADBEEF);

    // Reset held with a live hit on the bus.
    a_abus = 32'h0100860C; a_rnw = 1'b1; a_be = 4'hF; a_sel = 1'b1;
    b_abus = 32'h0100860C; b_rnw = 1'b1; b_be = 4'hF; b_sel = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_a_flags", {28'b0, a_ack, a_err, a_retry, a_tout}, 32'h0);
    check_eq("rst_a_dbus", a_dbus, 32'h0);
    check_eq("rst_b_flags", {28'b0, b_ack, b_err, b_retry, b_tout}, 32'h0);
    check_eq("rst_b_dbus", b_dbus, 32'h0);
    a_sel = 1'b0; b_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Read reg 3 with two wait states.
    read_a(32'h0100860C);
    check_eq("rd3_ack_cyc", ack_cyc, 32'd3);
    check_eq("rd3_ack_cnt", ack_cnt, 32'd1);
    check_eq("rd3_data", ack_data, 32'hDEADBEEF);
    check_eq("rd3_tout", {16'h0, tout_mask}, 32'h6);
    check_eq("rd3_err", err_cyc, 32'hFFFFFFFF);
    check_eq("rd3_dbus_idle", idle_dbus, 32'h0);

    // Zero-wait instance, back-to-back reads of reg 0 and reg 1.
    @(negedge clk);
    b_abus = 32'h01008600; b_rnw = 1'b1; b_be = 4'hF; b_sel = 1'b1;
    bmask = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (b_ack) bmask[c] = 1'b1;
      bd[c] = b_dbus;
      if (c == 1) b_abus = 32'h01008604;
      if (c == 3) b_sel = 1'b0;
    end
    check_eq("b2b_ack_mask", bmask, 32'h0000000A);
    check_eq("b2b_data0", bd[1], 32'h000000AA);
    check_eq("b2b_gap_dbus", bd[2], 32'h0);
    check_eq("b2b_data1", bd[3], 32'h11111111);

    // Offset 60 inside the window: error ack.
    read_a(32'h010086F0);
    check_eq("err_cyc", err_cyc, 32'd3);
    check_eq("err_ack_cnt", ack_cnt, 32'd0);
    check_eq("err_dbus", idle_dbus, 32'h0);

    // Just past the window: silence.
    read_a(32'h01008700);
    check_eq("oow_ack_cnt", ack_cnt, 32'd0);
    check_eq("oow_err", err_cyc, 32'hFFFFFFFF);
    check_eq("oow_tout", {16'h0, tout_mask}, 32'h0);

    read_a(32'h01008620);
    check_eq("ctrl_rd0_cyc", ack_cyc, 32'd3);
    check_eq("ctrl_rd0", ack_data, 32'h0);

    // Freeze, then move reg 0 underneath.
    xfer_a(32'h01008620, 1'b0, 4'b0001, 32'h1, 6, 0);
    check_eq("frz_wr_cyc", ack_cyc, 32'd3);
    check_eq("frz_wr_dbus", ack_data, 32'h0);
    set_reg(0, 32'h000000BB);
    read_a(32'h01008600);
    check_eq("frz_rd_reg0", ack_data, Snap ? 32'h000000AA : 32'h000000BB);
    read_a(32'h01008620);
    check_eq("frz_ctrl", ack_data, 32'h1);

    // BE[3] clear: freeze flag untouched.
    xfer_a(32'h01008620, 1'b0, 4'b1110, 32'h0, 6, 0);
    read_a(32'h01008620);
    check_eq("be_mask_ctrl", ack_data, 32'h1);

    // Select dropped during wait: no ack, no write.
    xfer_a(32'h01008620, 1'b0, 4'b1111, 32'h0, 6, 1);
    check_eq("abort_ack_cnt", ack_cnt, 32'd0);
    check_eq("abort_err", err_cyc, 32'hFFFFFFFF);
    read_a(32'h01008620);
    check_eq("abort_ctrl", ack_data, 32'h1);

    // Re-freezing while frozen keeps the first image.
    set_reg(0, 32'h000000CC);
    xfer_a(32'h01008620, 1'b0, 4'b0001, 32'h1, 6, 0);
    read_a(32'h01008600);
    check_eq("refrz_reg0", ack_data, Snap ? 32'h000000AA : 32'h000000CC);

    // Unfreeze: live again.
    set_reg(0, 32'h000000BB);
    xfer_a(32'h01008620, 1'b0, 4'b0001, 32'h0, 6, 0);
    read_a(32'h01008600);
    check_eq("unfrz_reg0", ack_data, 32'h000000BB);
    read_a(32'h01008620);
    check_eq("unfrz_ctrl", ack_data, 32'h0);

    // Freeze again, then reset in the middle of a wait.
    xfer_a(32'h01008620, 1'b0, 4'b0001, 32'h1, 6, 0);
    set_reg(0, 32'h000000CC);
    @(negedge clk);
    a_abus = 32'h01008600; a_rnw = 1'b1; a_be = 4'hF; a_sel = 1'b1;
    @(negedge clk);
    check_eq("rstw_tout_pre", {31'b0, a_tout}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_eq("rstw_flags", {28'b0, a_ack, a_err, a_retry, a_tout}, 32'h0);
    a_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    late_acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_ack || a_err) late_acks++;
    end
    check_eq("rstw_no_ack", late_acks, 32'd0);
    read_a(32'h01008620);
    check_eq("rstw_ctrl", ack_data, 32'h0);
    read_a(32'h01008600);
    check_eq("rstw_reg0_live", ack_data, 32'h000000CC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
